// File: rtl/abl_seq_if.sv
// abl_seq_if -- handshake and datapath-control bundle for the abl_seq microsequencer.
//
// Signals
//   start    sequencer launch request (one cycle)
//   mode     addressing mode: 0 ZP, 1 ZPX, 2 ABS, 3 ABSX, 4 REL, 5 STK, 6 INDY, 7 NOP
//   cond     branch condition
//   CO       ABL adder carry-out (same cycle)
//   db7      DB[7], sign of the branch offset
//   op       ABL operation code
//   ci       ABL carry-in
//   ld_ahl   load AHL from DB
//   ld_pc    load PCL
//   inc_pc   PCL increment
//   abh_inc  ABH +1 request
//   abh_dec  ABH -1 request
//   busy     sequence in progress
//   done     one-cycle completion pulse
//
// Modports
//   master   the side that requests sequences and supplies datapath status
//   slave    the sequencer itself
interface abl_seq_if;
  logic       start;
  logic [2:0] mode;
  logic       cond;
  logic       CO;
  logic       db7;
  logic [4:0] op;
  logic       ci;
  logic       ld_ahl;
  logic       ld_pc;
  logic       inc_pc;
  logic       abh_inc;
  logic       abh_dec;
  logic       busy;
  logic       done;

  modport master (
    output start, mode, cond, CO, db7,
    input  op, ci, ld_ahl, ld_pc, inc_pc, abh_inc, abh_dec, busy, done
  );

  modport slave (
    input  start, mode, cond, CO, db7,
    output op, ci, ld_ahl, ld_pc, inc_pc, abh_inc, abh_dec, busy, done
  );
endinterface

// File: rtl/abl_seq.sv
// abl_seq -- address-bus-low microsequencer.
//
// A one-cycle start with an addressing mode walks a fixed per-mode list of
// states. Each state drives the ABL op code, carry-in and the AHL/PCL strobes.
// The ABL carry-out is sampled to insert a page-cross fix cycle (S_FIX), in
// which the ABH logic is asked to increment or decrement.
//
// Ports
//   clk   clock
//   RST   synchronous active-high reset
//   bus   abl_seq_if.slave (start/mode/cond/CO/db7 in; op/ci/strobes/busy/done out)
//
// Parameters
//   BR_FIX  1: a taken branch that crosses a page inserts S_FIX; 0: never for REL.
//
// Build option
//   ABL_SEQ_FIX_ALWAYS_EN  when defined, ABSX and INDY always pass through
//                          S_FIX; abh_inc then carries the CO sampled on entry
//                          and abh_dec stays 0.
//
// Outputs are registered: the output decode looks at the next state, so the
// registered values equal a Moore decode of the current state.
module abl_seq #(
  parameter bit BR_FIX = 1'b1
) (
  input  logic      clk,
  input  logic      RST,
  abl_seq_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,  S_DONE = 4'd1,  S_ZP  = 4'd2,  S_ZPX = 4'd3,
    S_AL   = 4'd4,  S_AH   = 4'd5,  S_AHX = 4'd6,  S_BR  = 4'd7,
    S_ST   = 4'd8,  S_RET  = 4'd9,  S_P0  = 4'd10, S_P1  = 4'd11,
    S_PY   = 4'd12, S_FIX  = 4'd13
  } state_t;

  localparam logic [4:0] OP_HOLD = 5'b00011;
  localparam logic [4:0] OP_DBZ  = 5'b10010;
  localparam logic [4:0] OP_RDB  = 5'b10001;
  localparam logic [4:0] OP_AH0  = 5'b01110;
  localparam logic [4:0] OP_RAH  = 5'b01101;
  localparam logic [4:0] OP_STK  = 5'b00000;
  localparam logic [4:0] OP_PCR  = 5'b01010;
  localparam logic [4:0] OP_BRC  = 5'b11011;

  localparam logic [2:0] MODE_ABSX = 3'd3;

  state_t     state_r, state_nx_s;
  logic [2:0] mode_r, mode_nx_s;
  logic       dir_r, dir_nx_s;

  logic [4:0] op_s, op_r;
  logic       ci_s, ci_r, ld_ahl_s, ld_ahl_r, ld_pc_s, ld_pc_r;
  logic       inc_pc_s, inc_pc_r, abh_inc_s, abh_inc_r, abh_dec_s, abh_dec_r;
  logic       busy_s, busy_r, done_s, done_r;

  // First state of each mode's sequence.
  function automatic state_t first_state(input logic [2:0] m);
    state_t s;
    case (m)
      3'd0:    s = S_ZP;
      3'd1:    s = S_ZPX;
      3'd2:    s = S_AL;
      3'd3:    s = S_AL;
      3'd4:    s = S_BR;
      3'd5:    s = S_ST;
      3'd6:    s = S_P0;
      3'd7:    s = S_DONE;
      default: s = S_IDLE;
    endcase
    return s;
  endfunction

  // Next-state, latched mode and fix direction.
  always_comb begin
    state_nx_s = state_r;
    mode_nx_s  = mode_r;
    dir_nx_s   = dir_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        // start is only honoured here; S_DONE relaunches with no idle gap
        if (bus.start) begin
          state_nx_s = first_state(bus.mode);
          mode_nx_s  = bus.mode;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_ZP, S_ZPX, S_AH, S_RET, S_FIX: state_nx_s = S_DONE;
      S_AL: begin
        if (mode_r == MODE_ABSX) begin
          state_nx_s = S_AHX;
        end else begin
          state_nx_s = S_AH;
        end
      end
      S_AHX, S_PY: begin
`ifdef ABL_SEQ_FIX_ALWAYS_EN
        // fixed-timing indexed access: fix cycle always, carry decides the bump
        state_nx_s = S_FIX;
        dir_nx_s   = bus.CO;
`else
        if (bus.CO) begin
          state_nx_s = S_FIX;
          dir_nx_s   = 1'b1;
        end else begin
          state_nx_s = S_DONE;
        end
`endif
      end
      S_BR: begin
        // page crossed when the carry disagrees with the offset sign
        if (BR_FIX && bus.cond && (bus.CO != bus.db7)) begin
          state_nx_s = S_FIX;
          dir_nx_s   = bus.CO & ~bus.db7;
        end else begin
          state_nx_s = S_DONE;
        end
      end
      S_ST:    state_nx_s = S_RET;
      S_P0:    state_nx_s = S_P1;
      S_P1:    state_nx_s = S_PY;
      default: state_nx_s = S_IDLE;
    endcase
  end

  // Output decode of the state being entered.
  always_comb begin
    op_s      = OP_HOLD;
    ci_s      = 1'b0;
    ld_ahl_s  = 1'b0;
    ld_pc_s   = 1'b0;
    inc_pc_s  = 1'b0;
    abh_inc_s = 1'b0;
    abh_dec_s = 1'b0;
    busy_s    = 1'b1;
    done_s    = 1'b0;
    case (state_nx_s)
      S_IDLE: busy_s = 1'b0;
      S_DONE: begin
        busy_s = 1'b0;
        done_s = 1'b1;
      end
      S_ZP, S_P0: begin
        op_s = OP_DBZ; ld_pc_s = 1'b1; inc_pc_s = 1'b1;
      end
      S_ZPX: begin
        op_s = OP_RDB; ld_pc_s = 1'b1; inc_pc_s = 1'b1;
      end
      S_AL, S_P1: begin
        op_s = OP_HOLD; ci_s = 1'b1; ld_ahl_s = 1'b1;
      end
      S_AH: begin
        op_s = OP_AH0; ld_pc_s = 1'b1; inc_pc_s = 1'b1;
      end
      S_AHX: begin
        op_s = OP_RAH; ld_pc_s = 1'b1; inc_pc_s = 1'b1;
      end
      S_BR: begin
        op_s = OP_BRC; ld_pc_s = 1'b1; inc_pc_s = 1'b1;
      end
      S_ST:  op_s = OP_STK;
      S_RET: op_s = OP_PCR;
      S_PY:  op_s = OP_RAH;
      S_FIX: begin
        abh_inc_s = dir_nx_s;
`ifdef ABL_SEQ_FIX_ALWAYS_EN
        abh_dec_s = 1'b0;
`else
        abh_dec_s = ~dir_nx_s;
`endif
      end
      default: busy_s = 1'b0;
    endcase
  end

  // State, latched mode, fix direction and registered outputs.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r   <= S_IDLE;
      mode_r    <= 3'd0;
      dir_r     <= 1'b0;
      op_r      <= OP_HOLD;
      ci_r      <= 1'b0;
      ld_ahl_r  <= 1'b0;
      ld_pc_r   <= 1'b0;
      inc_pc_r  <= 1'b0;
      abh_inc_r <= 1'b0;
      abh_dec_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      mode_r    <= mode_nx_s;
      dir_r     <= dir_nx_s;
      op_r      <= op_s;
      ci_r      <= ci_s;
      ld_ahl_r  <= ld_ahl_s;
      ld_pc_r   <= ld_pc_s;
      inc_pc_r  <= inc_pc_s;
      abh_inc_r <= abh_inc_s;
      abh_dec_r <= abh_dec_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
    end
  end

  assign bus.op      = op_r;
  assign bus.ci      = ci_r;
  assign bus.ld_ahl  = ld_ahl_r;
  assign bus.ld_pc   = ld_pc_r;
  assign bus.inc_pc  = inc_pc_r;
  assign bus.abh_inc = abh_inc_r;
  assign bus.abh_dec = abh_dec_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_abl_seq.sv
// tb_abl_seq -- self-checking bench for abl_seq.
// A table of {mode, cond, CO, db7, latency} records is applied in a loop; for
// each, the expected per-cycle outputs are pushed to a scoreboard queue and
// popped/compared one per clock. Hand-written sequences cover reset,
// back-to-back launch, start-while-busy and reset mid-sequence.
module tb_abl_seq;

  localparam bit BR_FIX_TB = 1'b1;

  localparam logic [4:0] HOLD = 5'b00011;
  localparam logic [4:0] DBZ  = 5'b10010;
  localparam logic [4:0] RDB  = 5'b10001;
  localparam logic [4:0] AH0  = 5'b01110;
  localparam logic [4:0] RAH  = 5'b01101;
  localparam logic [4:0] STK  = 5'b00000;
  localparam logic [4:0] PCR  = 5'b01010;
  localparam logic [4:0] BRC  = 5'b11011;

  typedef struct packed {
    logic [4:0] op;
    logic ci; logic ld_ahl; logic ld_pc; logic inc_pc;
    logic abh_inc; logic abh_dec; logic busy; logic done;
  } outv_t;

  typedef struct {
    logic [2:0] mode;
    logic       cond;
    logic       co;
    logic       db7;
    int         lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  abl_seq_if bus ();
  abl_seq #(.BR_FIX(BR_FIX_TB)) dut (.clk(clk), .RST(rst), .bus(bus));

  outv_t sbq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc;
  int    done_at;
  vec_t  vecs[14];

  function automatic outv_t mk(input logic [4:0] op, input logic ci, input logic ahl,
                               input logic ldpc, input logic incpc, input logic inc,
                               input logic dec, input logic busy, input logic done);
    outv_t r;
    r.op = op; r.ci = ci; r.ld_ahl = ahl; r.ld_pc = ldpc; r.inc_pc = incpc;
    r.abh_inc = inc; r.abh_dec = dec; r.busy = busy; r.done = done;
    return r;
  endfunction

  function automatic outv_t e_idle();
    return mk(HOLD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic outv_t e_done();
    return mk(HOLD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic outv_t e_pcld(input logic [4:0] op);
    return mk(op, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic outv_t e_al();
    return mk(HOLD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic outv_t e_plain(input logic [4:0] op);
    return mk(op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic outv_t e_fix(input logic inc, input logic dec);
    return mk(HOLD, 1'b0, 1'b0, 1'b0, 1'b0, inc, dec, 1'b1, 1'b0);
  endfunction

  function automatic outv_t get_out();
    return mk(bus.op, bus.ci, bus.ld_ahl, bus.ld_pc, bus.inc_pc,
              bus.abh_inc, bus.abh_dec, bus.busy, bus.done);
  endfunction

  task automatic push_indexed_fix(input logic co);
`ifdef ABL_SEQ_FIX_ALWAYS_EN
    sbq.push_back(e_fix(co, 1'b0));
`else
    if (co) sbq.push_back(e_fix(1'b1, 1'b0));
`endif
  endtask

  // Expected per-cycle outputs of one sequence, ending with S_DONE.
  task automatic push_seq(input logic [2:0] m, input logic cond, input logic co, input logic db7);
    logic fwd;
    case (m)
      3'd0: sbq.push_back(e_pcld(DBZ));
      3'd1: sbq.push_back(e_pcld(RDB));
      3'd2: begin sbq.push_back(e_al()); sbq.push_back(e_pcld(AH0)); end
      3'd3: begin sbq.push_back(e_al()); sbq.push_back(e_pcld(RAH)); push_indexed_fix(co); end
      3'd4: begin
        sbq.push_back(e_pcld(BRC));
        fwd = co & ~db7;
        if (BR_FIX_TB && cond && (co != db7)) sbq.push_back(e_fix(fwd, ~fwd));
      end
      3'd5: begin sbq.push_back(e_plain(STK)); sbq.push_back(e_plain(PCR)); end
      3'd6: begin
        sbq.push_back(e_pcld(DBZ)); sbq.push_back(e_al()); sbq.push_back(e_plain(RAH));
        push_indexed_fix(co);
      end
      default: ;
    endcase
    sbq.push_back(e_done());
  endtask

  task automatic cmp(input string name, input outv_t got, input outv_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc %0d: got op=%b ci/ahl/ldpc/incpc/inc/dec/busy/done=%b expected op=%b %b",
               name, cyc, got.op, got[7:0], exp.op, exp[7:0]);
    end
  endtask

  // One clock: sample at the falling edge and compare against the queue head.
  task automatic step_check(input string name);
    outv_t g;
    @(negedge clk);
    cyc++;
    g = get_out();
    if (sbq.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s cyc %0d: scoreboard empty, got op=%b", name, cyc, g.op);
    end else begin
      cmp(name, g, sbq.pop_front());
    end
    if (g.done && done_at == 0) done_at = cyc;
  endtask

  task automatic run_vec(input int idx);
    int n;
    string nm;
    nm = $sformatf("vec%0d_mode%0d", idx, vecs[idx].mode);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = vecs[idx].mode; bus.cond = vecs[idx].cond;
    bus.CO = vecs[idx].co; bus.db7 = vecs[idx].db7;
    push_seq(vecs[idx].mode, vecs[idx].cond, vecs[idx].co, vecs[idx].db7);
    sbq.push_back(e_idle());
    cyc = 0; done_at = 0;
    n = sbq.size();
    for (int k = 0; k < n; k++) begin
      step_check(nm);
      if (k == 0) bus.start = 1'b0;
    end
    n_cmp++;
    if (done_at != vecs[idx].lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d expected %0d", nm, done_at, vecs[idx].lat);
    end
  endtask

  initial begin
    //           mode  cond  CO    db7   latency
    vecs[0]  = '{3'd0, 1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{3'd1, 1'b0, 1'b1, 1'b0, 2};
    vecs[2]  = '{3'd2, 1'b0, 1'b1, 1'b0, 3};
    vecs[3]  = '{3'd3, 1'b0, 1'b1, 1'b0, 4};
    vecs[4]  = '{3'd3, 1'b0, 1'b0, 1'b0, 3};
    vecs[5]  = '{3'd6, 1'b0, 1'b1, 1'b0, 5};
    vecs[6]  = '{3'd6, 1'b0, 1'b0, 1'b0, 4};
    vecs[7]  = '{3'd4, 1'b1, 1'b0, 1'b1, 3};
    vecs[8]  = '{3'd4, 1'b1, 1'b1, 1'b0, 3};
    vecs[9]  = '{3'd4, 1'b1, 1'b1, 1'b1, 2};
    vecs[10] = '{3'd4, 1'b1, 1'b0, 1'b0, 2};
    vecs[11] = '{3'd4, 1'b0, 1'b0, 1'b1, 2};
    vecs[12] = '{3'd5, 1'b0, 1'b0, 1'b0, 3};
    vecs[13] = '{3'd7, 1'b0, 1'b0, 1'b0, 1};
`ifdef ABL_SEQ_FIX_ALWAYS_EN
    vecs[4].lat = 4;
    vecs[6].lat = 5;
`endif

    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 3'd0; bus.cond = 1'b0; bus.CO = 1'b0; bus.db7 = 1'b0;
    cyc = 0; done_at = 0;

    // reset held for two edges: idle outputs
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp("reset", get_out(), e_idle());
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(i);

    // STK then ZP back-to-back; a start during S_ST is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 3'd5; bus.CO = 1'b0; bus.db7 = 1'b0; bus.cond = 1'b0;
    push_seq(3'd5, 1'b0, 1'b0, 1'b0);
    push_seq(3'd0, 1'b0, 1'b0, 1'b0);
    sbq.push_back(e_idle());
    cyc = 0; done_at = 0;
    step_check("b2b");                     // S_ST, start still high
    bus.mode = 3'd7;
    step_check("b2b");                     // S_RET
    bus.start = 1'b0;
    step_check("b2b");                     // S_DONE: relaunch as ZP
    bus.start = 1'b1; bus.mode = 3'd0;
    step_check("b2b");                     // S_ZP
    bus.start = 1'b0;
    step_check("b2b");                     // S_DONE
    step_check("b2b");                     // S_IDLE

    // reset during S_P1 of INDY, with a start in the same cycle
    @(negedge clk);
    bus.start = 1'b1; bus.mode = 3'd6; bus.CO = 1'b1;
    sbq.push_back(e_pcld(DBZ));
    sbq.push_back(e_al());
    sbq.push_back(e_idle());
    sbq.push_back(e_idle());
    cyc = 0; done_at = 0;
    step_check("rst_indy");                // S_P0
    bus.start = 1'b0;
    step_check("rst_indy");                // S_P1
    rst = 1'b1; bus.start = 1'b1; bus.mode = 3'd0;
    step_check("rst_indy");                // idle after reset
    rst = 1'b0; bus.start = 1'b0;
    step_check("rst_indy");                // still idle

    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sbq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/abl_seq.md
Name: abl_seq

Overview:
- Microsequencer for the address-bus-low datapath.
- Given a one-cycle `start` and an addressing `mode`, it steps through fixed per-mode states.
- In each state it drives the ABL `op`, carry-in `ci`, and the AHL/PCL load strobes.
- It samples the ABL carry-out (`CO`) to insert a page-cross fix cycle, and signals the ABH logic to increment or decrement.

Parameters:
- BR_FIX, 1, branch page-cross fix enable. 1: a taken branch that crosses a page inserts S_FIX. 0: branch never inserts S_FIX; `abh_inc` and `abh_dec` are never asserted for REL.

Ports:
- clk  in  1  clock
- RST  in  1  synchronous active-high reset
- start  in  1  begin sequence; accepted only in S_IDLE or S_DONE
- mode  in  3  0 ZP, 1 ZPX, 2 ABS, 3 ABSX, 4 REL, 5 STK, 6 INDY, 7 NOP
- cond  in  1  branch condition; passed through to the ABL datapath
- CO  in  1  ABL adder carry-out, same cycle
- db7  in  1  DB[7], the branch-offset sign
- op  out  5  ABL operation code
- ci  out  1  ABL carry-in
- ld_ahl  out  1  load AHL from DB
- ld_pc  out  1  load PCL
- inc_pc  out  1  PCL increment
- abh_inc  out  1  ABH +1 request
- abh_dec  out  1  ABH -1 request
- busy  out  1  high in every state except S_IDLE and S_DONE
- done  out  1  one-cycle completion pulse

Behaviour:
- Op codes:
  - HOLD = 00011 (ABL+0+ci)
  - DBZ = 10010 (DB+ci)
  - RDB = 10001 (REG+DB)
  - AH0 = 01110 (AHL+0)
  - RAH = 01101 (REG+AHL)
  - STK = 00000 (REG+ci)
  - PCR = 01010 (PCL+0)
  - BRC = 11011 (cond ? ABL+DB : ABL)
- Output model: Moore. Outputs decode from state only, except the next-state choice on CO.
- Unlisted strobes in any state are 0.
- State outputs:
  - S_IDLE: op=HOLD, ci=0.
  - S_DONE: op=HOLD, ci=0, done=1.
  - S_ZP: op=DBZ, ld_pc=1, inc_pc=1.
  - S_ZPX: op=RDB, ld_pc=1, inc_pc=1. CO is ignored (zero-page wrap).
  - S_AL: op=HOLD, ci=1, ld_ahl=1.
  - S_AH: op=AH0, ld_pc=1, inc_pc=1.
  - S_AHX: op=RAH, ld_pc=1, inc_pc=1.
  - S_BR: op=BRC, ld_pc=1, inc_pc=1.
  - S_ST: op=STK.
  - S_RET: op=PCR.
  - S_P0: op=DBZ, ld_pc=1, inc_pc=1.
  - S_P1: op=HOLD, ci=1, ld_ahl=1.
  - S_PY: op=RAH.
  - S_FIX: op=HOLD, ci=0, abh_inc=dir, abh_dec=~dir.
- Sequences (the cycle after `start` is the first listed state):
  - ZP: S_ZP → S_DONE
  - ZPX: S_ZPX → S_DONE
  - ABS: S_AL → S_AH → S_DONE
  - ABSX: S_AL → S_AHX → (CO ? S_FIX : S_DONE)
  - INDY: S_P0 → S_P1 → S_PY → (CO ? S_FIX : S_DONE)
  - REL: S_BR → (BR_FIX && cond && CO≠db7 ? S_FIX : S_DONE)
  - STK: S_ST → S_RET → S_DONE
  - NOP: S_DONE directly
- S_FIX always leads to S_DONE.
- Fix direction register `dir`:
  - Captured on the entry edge into S_FIX.
  - For indexed modes, dir=1.
  - For REL, dir = CO & ~db7 (forward crossing). CO=0 with db7=1 gives dir=0 (backward crossing).
- S_DONE → S_IDLE, unless `start`=1, which launches the next mode directly with no idle gap.
- `start` while busy is ignored. `mode` is sampled only on the accepting edge and latched internally.
- Latency from `start` to `done`:
  - ZP/ZPX: 2 cycles
  - ABS: 3 cycles
  - ABSX: 3 cycles, or 4 with fix
  - INDY: 4 cycles, or 5 with fix
  - REL: 2 cycles, or 3 with fix
  - STK: 3 cycles
  - NOP: 1 cycle
- Reset: RST=1 at a clock edge forces S_IDLE and dir=0 regardless of state, including mid-sequence. All outputs take their S_IDLE values (op=00011, others 0) from the next cycle. Reset wins over `start` in the same cycle.

Optional Feature:
- Macro: ABL_SEQ_FIX_ALWAYS_EN.
- Defined: ABSX and INDY always pass through S_FIX, irrespective of CO (fixed-timing indexed access). In this case abh_inc = the CO value sampled on entry, and abh_dec=0. REL is unaffected.
- Not defined: S_FIX is taken only on CO as specified above.

Test Plan:
- Reset then idle: RST=1 for 2 cycles → op=00011, busy=0, done=0 and all strobes 0.
- ZP: start with mode=0 → next cycle op=10010, ld_pc=1, inc_pc=1; the following cycle done=1; then idle.
- ABSX, both carry cases:
  - CO=1 in S_AHX → op sequence 00011(ci=1,ld_ahl=1), 01101, 00011 with abh_inc=1, then done at cycle 4.
  - CO=0 in S_AHX → done at cycle 3, abh_inc never asserted.
- REL, BR_FIX=1, cond=1:
  - CO=0, db7=1 → S_FIX with abh_dec=1.
  - CO=1, db7=1 → no fix, done at cycle 2.
  - cond=0 → no fix.
- STK back-to-back: start with mode=5, and start asserted again with mode=0 during S_DONE → ops 00000, 01010, then 10010 with no S_IDLE cycle between sequences.
- Reset mid-INDY: RST asserted during S_P1 → next cycle S_IDLE outputs; a start pulse held in that same RST cycle is ignored.
